// File: rtl/rv_fetch_pkg.sv
// Shared types and helpers for the RV32IC instruction fetch path.
package rv_fetch_pkg;

  typedef logic [15:0] halfword_t;
  typedef logic [31:0] word_t;

  localparam logic [1:0] OPC_QUAD_32 = 2'b11;

  function automatic logic is_compressed(input halfword_t hw);
    return hw[1:0] != OPC_QUAD_32;
  endfunction

endpackage

// File: rtl/fetch_aligner_pc_adder.sv
// Next-PC adder: steps the current instruction PC by its encoded length.
module fetch_aligner_pc_adder
  import rv_fetch_pkg::*;
(
  input  word_t pc_current,
  input  logic  Inst_Compr,
  output word_t pc_next
);

  assign pc_next = pc_current + (Inst_Compr ? 32'd2 : 32'd4);

endmodule

// File: rtl/fetch_aligner.sv
// RV32IC fetch aligner: buffers instruction-memory halfwords and hands decode
// one whole 16- or 32-bit instruction per cycle with its PC.
module fetch_aligner
  import rv_fetch_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000,
  parameter int    BUF_HW   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] fetch_addr,
  output logic        fetch_ready,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        Inst_Compr
);

  localparam int CW = $clog2(BUF_HW + 1);

  halfword_t      hw_q [BUF_HW];
  halfword_t      hw_d [BUF_HW];
  logic [CW-1:0]  count_q;
  logic [CW-1:0]  count_d;
  word_t          fetch_addr_q;
  word_t          inst_pc_q;
  word_t          pc_next;
  logic           skip_q;
  logic           head_compr;
  logic           accept;
  logic           consume;
  logic [1:0]     pop_n;
  logic [1:0]     push_n;
  int             base_idx;

  // Decode is purely from registered buffer state, so outputs hold while stalled.
  assign head_compr  = is_compressed(hw_q[0]);
  assign inst_valid  = (count_q != '0 && head_compr) || (count_q >= CW'(2) && !head_compr);
  assign Inst_Compr  = inst_valid && head_compr;
  assign inst        = !inst_valid ? 32'h0 :
                       head_compr  ? {16'h0, hw_q[0]} : {hw_q[1], hw_q[0]};
  assign inst_pc     = inst_pc_q;
  assign fetch_addr  = fetch_addr_q;
  assign fetch_ready = (count_q <= CW'(BUF_HW - 2)) && !redirect_valid;

  assign accept   = fetch_valid && fetch_ready;
  assign consume  = inst_valid && inst_ready;
  assign pop_n    = consume ? (head_compr ? 2'd1 : 2'd2) : 2'd0;
  assign push_n   = accept ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
  assign base_idx = int'(count_q) - int'(pop_n);

  // Shift out consumed halfwords, then append the new word behind the survivors.
  always_comb begin
    for (int i = 0; i < BUF_HW; i++) begin
      hw_d[i] = '0;
      if (i + int'(pop_n) < BUF_HW && i < base_idx)
        hw_d[i] = hw_q[i + int'(pop_n)];
      if (push_n == 2'd2) begin
        if (i == base_idx)     hw_d[i] = fetch_data[15:0];
        if (i == base_idx + 1) hw_d[i] = fetch_data[31:16];
      end else if (push_n == 2'd1 && i == base_idx) begin
        hw_d[i] = fetch_data[31:16];
      end
    end
    count_d = count_q - CW'(pop_n) + CW'(push_n);
  end

  fetch_aligner_pc_adder u_pc_adder (
    .pc_current (inst_pc_q),
    .Inst_Compr (Inst_Compr),
    .pc_next    (pc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      for (int i = 0; i < BUF_HW; i++) hw_q[i] <= '0;
      fetch_addr_q <= {RESET_PC[31:2], 2'b00};
      inst_pc_q    <= RESET_PC;
      skip_q       <= RESET_PC[1];
    end else if (redirect_valid) begin
      count_q      <= '0;
      for (int i = 0; i < BUF_HW; i++) hw_q[i] <= '0;
      fetch_addr_q <= {redirect_pc[31:2], 2'b00};
      inst_pc_q    <= {redirect_pc[31:1], 1'b0};
      skip_q       <= redirect_pc[1];
    end else begin
      count_q <= count_d;
      for (int i = 0; i < BUF_HW; i++) hw_q[i] <= hw_d[i];
      if (accept) begin
        fetch_addr_q <= fetch_addr_q + 32'd4;
        skip_q       <= 1'b0;
      end
      if (consume) inst_pc_q <= pc_next;
    end
  end

endmodule
